// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner and its front-panel users.
package keypad_scanner_pkg;

    localparam int unsigned KEY_W = 4;
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    typedef enum logic {
        IDLE,
        PRESSED
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } cls_e;

    // code is only meaningful for CLS_SINGLE; kept at 0 for CLS_NONE so the
    // whole struct can be compared frame to frame.
    typedef struct packed {
        cls_e             cls;
        logic [KEY_W-1:0] code;
    } frame_cls_t;

    // Bit i of pressed is key {row, col} = i, so the index is the key code.
    function automatic frame_cls_t classify(input logic [15:0] pressed);
        frame_cls_t  res;
        int unsigned n;
        n        = 0;
        res.cls  = CLS_NONE;
        res.code = '0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                n++;
                res.code = KEY_W'(i);
            end
        end
        if (n == 1) begin
            res.cls = CLS_SINGLE;
        end else if (n > 1) begin
            res.cls = CLS_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix lines plus the key valid/ack handshake.
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;

    logic [3:0]       row_n;
    logic [3:0]       col_n;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ack;
    logic             key_down;
    logic             overrun;

    // master: the scanner itself
    modport master (
        output row_n,
        output key_code,
        output key_valid,
        output key_down,
        output overrun,
        input  col_n,
        input  key_ack
    );

    // slave: keypad matrix and key consumer
    modport slave (
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  overrun,
        output col_n,
        output key_ack
    );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous front-panel inputs; idles at all-ones.
module keypad_scanner_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Shift the async input through two flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row multiplexing, frame debounce, key handshake.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input logic              clk_50mhz,
    input logic              reset,
    keypad_scanner_if.master kp
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_row_n;
    logic [15:0]      r_frame;
    logic             r_frame_done;
    frame_cls_t       r_cand;
    logic [3:0]       r_stable_cnt;
    state_e           r_state;
    state_e           w_state_next;
    logic             w_press_evt;
    logic             r_key_valid;
    logic [KEY_W-1:0] r_key_code;
    logic             r_overrun;
    logic [3:0]       w_col_sync;
    logic             w_tc;
    frame_cls_t       w_cls;
    logic             w_qualified;

    keypad_scanner_sync_2ff #(
        .WIDTH (4)
    ) u_col_sync (
        .i_clk   (clk_50mhz),
        .i_reset (reset),
        .i_async (kp.col_n),
        .o_sync  (w_col_sync)
    );

    assign w_tc = (r_div == DIV_W'(SCAN_DIV - 1));

    // Row dwell counter, row strobe rotation and end-of-dwell column capture.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_div        <= '0;
            r_row_idx    <= '0;
            r_row_n      <= ROW_FIRST;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tc && (r_row_idx == 2'd3);
            if (w_tc) begin
                r_div                              <= '0;
                r_frame[{r_row_idx, 2'b00} +: 4]   <= ~w_col_sync;
                r_row_idx                          <= r_row_idx + 2'd1;
                r_row_n                            <= {r_row_n[2:0], r_row_n[3]};
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // r_frame is stable for several cycles after the last row lands.
    assign w_cls = classify(r_frame);

    // Per-frame debounce: count consecutive identical classifications.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_cand       <= '{cls: CLS_NONE, code: '0};
            r_stable_cnt <= '0;
        end else if (r_frame_done) begin
            if (w_cls.cls == CLS_MULTI) begin
                r_cand       <= w_cls;
                r_stable_cnt <= '0;
            end else if (w_cls == r_cand) begin
                if (r_stable_cnt < 4'(DEBOUNCE)) begin
                    r_stable_cnt <= r_stable_cnt + 4'd1;
                end
            end else begin
                r_cand       <= w_cls;
                r_stable_cnt <= 4'd1;
            end
        end
    end

    assign w_qualified = (r_stable_cnt == 4'(DEBOUNCE));

    // Press/release state register.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; the IDLE->PRESSED transition is the one press event.
    always_comb begin
        w_state_next = r_state;
        w_press_evt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_cand.cls == CLS_SINGLE && w_qualified) begin
                    w_state_next = PRESSED;
                    w_press_evt  = 1'b1;
                end
            end
            PRESSED: begin
                // A different key or a chord while held is ignored until release.
                if (r_cand.cls == CLS_NONE && w_qualified) begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    // Key handshake; an unacknowledged key is kept and later presses are dropped.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overrun   <= 1'b0;
        end else if (w_press_evt) begin
            if (!r_key_valid) begin
                r_key_code  <= r_cand.code;
                r_key_valid <= 1'b1;
            end else if (kp.key_ack) begin
                r_key_code <= r_cand.code;
                r_overrun  <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_key_valid && kp.key_ack) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign kp.row_n     = r_row_n;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_down  = (r_state == PRESSED);
    assign kp.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 2;
    localparam int          FRAME    = 16;

    typedef struct {
        logic [15:0] keys;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_down;
    } vec_t;

    logic        clk_50mhz = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] keys      = '0;
    logic [3:0]  col_model;
    int          n_checks  = 0;
    int          n_fail    = 0;
    vec_t        vecs[7];
    logic [3:0]  row_tab[4];

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .kp        (kif)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Key matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        col_model = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[r*4+c] && !kif.row_n[r]) col_model[c] = 1'b0;
            end
        end
    end
    assign kif.col_n = col_model;

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic ack_pulse();
        kif.key_ack = 1'b1;
        tick();
        kif.key_ack = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!kif.key_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_n"}, 32'(kif.row_n), 32'h0000000e);
        check({tag, "_key_valid"}, 32'(kif.key_valid), 32'd0);
        check({tag, "_key_down"}, 32'(kif.key_down), 32'd0);
        check({tag, "_overrun"}, 32'(kif.overrun), 32'd0);
        check({tag, "_key_code"}, 32'(kif.key_code), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic saw_valid;
        logic saw_down;

        kif.key_ack = 1'b0;
        row_tab[0] = 4'b1110;
        row_tab[1] = 4'b1101;
        row_tab[2] = 4'b1011;
        row_tab[3] = 4'b0111;
        vecs[0] = '{16'h0001, 1'b1, 4'h0, 1'b1};
        vecs[1] = '{16'h8000, 1'b1, 4'hF, 1'b1};
        vecs[2] = '{16'h0040, 1'b1, 4'h6, 1'b1};
        vecs[3] = '{16'h1000, 1'b1, 4'hC, 1'b1};
        vecs[4] = '{16'h8001, 1'b0, 4'h0, 1'b0};
        vecs[5] = '{16'h0030, 1'b0, 4'h0, 1'b0};
        vecs[6] = '{16'h0400, 1'b1, 4'hA, 1'b1};

        // Reset values and row strobe sequence.
        do_reset();
        check_reset_outputs("rst");
        for (int i = 1; i < 32; i++) begin
            tick();
            check($sformatf("row_seq_%0d", i), 32'(kif.row_n), 32'(row_tab[(i / 4) % 4]));
        end
        check("idle_valid", 32'(kif.key_valid), 32'd0);

        // Key 9 held from frame start: valid after two frames plus pipeline.
        keys = 16'h0200;
        do_reset();
        wait_valid(3 * FRAME, n);
        check("k9_latency_ok", 32'(n >= 32 && n <= 35), 32'd1);
        check("k9_valid", 32'(kif.key_valid), 32'd1);
        check("k9_code", 32'(kif.key_code), 32'h9);
        check("k9_down", 32'(kif.key_down), 32'd1);
        ack_pulse();
        check("k9_ack_clears", 32'(kif.key_valid), 32'd0);
        ticks(3 * FRAME);
        check("k9_single_event", 32'(kif.key_valid), 32'd0);
        check("k9_still_down", 32'(kif.key_down), 32'd1);
        keys = '0;
        ticks(4 * FRAME);
        check("k9_released", 32'(kif.key_down), 32'd0);

        // Table of single keys and chords.
        for (int v = 0; v < 7; v++) begin
            keys = vecs[v].keys;
            ticks(4 * FRAME);
            check($sformatf("vec%0d_valid", v), 32'(kif.key_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_down", v), 32'(kif.key_down), 32'(vecs[v].exp_down));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_code", v), 32'(kif.key_code), 32'(vecs[v].exp_code));
            end
            if (kif.key_valid) begin
                ack_pulse();
                check($sformatf("vec%0d_ack", v), 32'(kif.key_valid), 32'd0);
            end
            keys = '0;
            ticks(4 * FRAME);
            check($sformatf("vec%0d_release", v), 32'(kif.key_down), 32'd0);
        end

        // Bouncing key 5: alternates every frame, must never qualify.
        saw_valid = 1'b0;
        saw_down  = 1'b0;
        for (int f = 0; f < 8; f++) begin
            keys = (f % 2 == 0) ? 16'h0020 : 16'h0000;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (kif.key_valid) saw_valid = 1'b1;
                if (kif.key_down) saw_down = 1'b1;
            end
        end
        check("bounce_no_valid", 32'(saw_valid), 32'd0);
        check("bounce_no_down", 32'(saw_down), 32'd0);
        keys = '0;
        ticks(4 * FRAME);

        // Chord 0+F, then drop F: key 0 is reported.
        keys = 16'h8001;
        ticks(4 * FRAME);
        check("chord_no_valid", 32'(kif.key_valid), 32'd0);
        keys = 16'h0001;
        ticks(4 * FRAME);
        check("chord_then_0_valid", 32'(kif.key_valid), 32'd1);
        check("chord_then_0_code", 32'(kif.key_code), 32'h0);
        ack_pulse();
        keys = '0;
        ticks(4 * FRAME);

        // Overrun: key 3 unacknowledged, key A is dropped.
        keys = 16'h0008;
        ticks(4 * FRAME);
        check("ovr_k3_valid", 32'(kif.key_valid), 32'd1);
        keys = '0;
        ticks(4 * FRAME);
        keys = 16'h0400;
        ticks(4 * FRAME);
        check("ovr_code_kept", 32'(kif.key_code), 32'h3);
        check("ovr_valid_held", 32'(kif.key_valid), 32'd1);
        check("ovr_flag", 32'(kif.overrun), 32'd1);
        keys = '0;
        ticks(4 * FRAME);
        check("ovr_sticky", 32'(kif.overrun), 32'd1);
        ack_pulse();
        check("ovr_ack_valid", 32'(kif.key_valid), 32'd0);
        check("ovr_ack_clear", 32'(kif.overrun), 32'd0);
        ticks(2);
        check("ack_ignored_idle", 32'(kif.key_valid), 32'd0);

        // Reset while key 7 is held in PRESSED, then re-report after debounce.
        keys = 16'h0080;
        ticks(4 * FRAME);
        check("k7_down_before_rst", 32'(kif.key_down), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");
        wait_valid(3 * FRAME, n);
        check("k7_relatency_ok", 32'(n >= 32 && n <= 35), 32'd1);
        check("k7_valid", 32'(kif.key_valid), 32'd1);
        check("k7_code", 32'(kif.key_code), 32'h7);
        check("k7_down", 32'(kif.key_down), 32'd1);
        ack_pulse();
        keys = '0;
        ticks(4 * FRAME);
        check("k7_released", 32'(kif.key_down), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
